fir_sample_sequencer: RTL
=========================

Name: fir_sample_sequencer

Overview:
- Control block that sits in front of the time-multiplexed optimised FIR filter.
- Accepts one input sample per strobe from the acquisition front end and launches exactly one filter computation per accepted sample (one-cycle `fir_en`).
- Waits a fixed filter latency, then captures the filter result and presents it with a one-cycle valid pulse.
- Owns the coefficient registers: writes are staged and applied only when no computation is in flight. Detects and counts samples dropped because the filter was busy.

Parameters:
- N, 16, sample/coefficient/result width.
- LAT, 6, filter cycles from the `fir_en` pulse to a stable `fir_y`; must be >= 1.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- enable  input  1  sequencer enable; low = new strobes ignored
- s_strobe  input  1  one-cycle pulse: s_data holds a new sample
- s_data  input  N  signed input sample
- cfg_we  input  1  configuration write strobe
- cfg_addr  input  2  0 = b0 stage, 1 = b1 stage, 2 = clear status, 3 = reserved (ignored)
- cfg_wdata  input  N  configuration write data
- fir_en  output  1  one-cycle launch pulse to the filter
- fir_x  output  N  sample presented to the filter
- fir_b0  output  N  active coefficient 0
- fir_b1  output  N  active coefficient 1
- fir_y  input  N  filter result
- y_valid  output  1  one-cycle pulse: y_data updated
- y_data  output  N  captured filter result, held until the next capture
- busy  output  1  high when the FSM is not in IDLE
- overrun  output  1  sticky: at least one sample dropped
- drop_cnt  output  CNT_W  saturating count of dropped samples

Behaviour:
- Reset (`rst` low, asynchronous): state = IDLE; staged and active coefficients = 0; pending = 0; `fir_en`, `fir_x`, `y_valid`, `y_data`, `overrun`, `drop_cnt` = 0. All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE.
  - IDLE -> LAUNCH when `s_strobe && enable`; `s_data` is latched into `fir_x` on that edge.
  - LAUNCH, 1 cycle: `fir_en` = 1 during exactly this cycle; wait counter loads LAT. -> WAIT.
  - WAIT, LAT cycles: counter decrements; at 1 -> CAPTURE.
  - CAPTURE, 1 cycle: `y_data` <= `fir_y` at the end of the cycle; `y_valid` = 1 during the following cycle (IDLE). -> IDLE.
- Latency: strobe accepted in cycle 0 -> `fir_en` in cycle 1 -> CAPTURE in cycle LAT+2 -> `y_valid` in cycle LAT+3.
- Accepting new samples:
  - IDLE accepts a strobe even in the same cycle that `y_valid` is high.
  - Minimum sample spacing is LAT+3 cycles.
- `fir_x` holds its value outside LAUNCH (no reload until the next accepted strobe).
- Coefficient writes:
  - Address 0/1 updates the staged register at the next edge and sets pending.
  - Whenever the FSM is in IDLE with pending set, active <= staged and pending is cleared at that edge.
  - A write in the same cycle as an apply: the new value is staged and pending remains set.
  - Active coefficients never change in LAUNCH, WAIT or CAPTURE.
  - A strobe accepted in an apply cycle launches with the newly applied coefficients, which are visible in the LAUNCH cycle.
- Drops: a strobe while `busy` with `enable` = 1 is discarded.
  - `overrun` <= 1.
  - `drop_cnt` increments, saturating at 2^CNT_W-1.
  - The in-flight computation is unaffected.
- Clear status: write to address 2 (any data) clears `overrun` and `drop_cnt`. If a drop occurs in the same cycle, the clear wins (result 0/0).
- `enable` low:
  - Strobes are ignored and are not counted as drops.
  - An in-flight computation completes normally, including `y_valid`.
  - Coefficient writes still function.
- Reset asserted mid-operation: immediate return to reset values. No `y_valid` is produced for the aborted sample.

Test Plan:
- Reset -> all outputs 0, `busy` = 0; deassert reset, hold idle 10 cycles -> `fir_en` never pulses.
- Write b0 = 0x4000, b1 = 0x2000 while idle, then strobe `s_data` = 0x1000 with the filter model driving `fir_y` = 0x0C00 (LAT = 6):
  - `fir_b0`/`fir_b1` read 0x4000/0x2000 by the LAUNCH cycle.
  - `fir_x` = 0x1000.
  - One `fir_en` pulse in cycle 1.
  - `y_valid` in cycle 9 with `y_data` = 0x0C00.
- Write b0 = 0x7FFF during WAIT -> `fir_b0` stays 0x4000 until the FSM returns to IDLE, then reads 0x7FFF one cycle later; the next computation uses 0x7FFF.
- Strobe during WAIT -> no extra `fir_en`, `overrun` = 1, `drop_cnt` = 1. Then 300 busy strobes -> `drop_cnt` = 255. Then write address 2 -> `overrun` = 0, `drop_cnt` = 0.
- Deassert `enable` in WAIT -> computation completes with `y_valid`; strobes while `enable` = 0 produce no `fir_en` and leave `drop_cnt` unchanged.
- Assert `rst` low in the middle of WAIT (asynchronously, off clock edge) -> outputs zero immediately, no `y_valid`; after release the next strobe yields normal LAT+3 latency.

Source files
------------

// File: rtl/fir_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_sample_sequencer
// Description : Front-end sequencer for a time-multiplexed FIR filter.
//               Launches one filter run per accepted sample, captures the
//               result after a fixed latency, owns the coefficient
//               registers and counts samples dropped while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_sequencer #(
  parameter int N     = 16,
  parameter int LAT   = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             s_strobe,
  input  logic [N-1:0]     s_data,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [N-1:0]     cfg_wdata,
  output logic             fir_en,
  output logic [N-1:0]     fir_x,
  output logic [N-1:0]     fir_b0,
  output logic [N-1:0]     fir_b1,
  input  logic [N-1:0]     fir_y,
  output logic             y_valid,
  output logic [N-1:0]     y_data,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] drop_cnt
);

  // Wait counter must be able to hold LAT itself.
  localparam int WCW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [N-1:0]   b0_stage;
  logic [N-1:0]   b1_stage;
  logic           pending;

  logic accept;
  logic drop;
  logic clear;
  logic wr_b0;
  logic wr_b1;

  assign accept = (state == S_IDLE) && s_strobe && enable;
  assign drop   = (state != S_IDLE) && s_strobe && enable;
  assign clear  = cfg_we && (cfg_addr == 2'd2);
  assign wr_b0  = cfg_we && (cfg_addr == 2'd0);
  assign wr_b1  = cfg_we && (cfg_addr == 2'd1);

  // Sequencing FSM: launch, fixed-latency wait, capture, with registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fir_en   <= 1'b0;
      fir_x    <= '0;
      y_valid  <= 1'b0;
      y_data   <= '0;
      busy     <= 1'b0;
    end else begin
      fir_en  <= 1'b0;
      y_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_LAUNCH;
            fir_x  <= s_data;
            fir_en <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_LAUNCH: begin
          wait_cnt <= WCW'(LAT);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WCW'(1)) begin
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - WCW'(1);
          end
        end
        S_CAPTURE: begin
          y_data  <= fir_y;
          y_valid <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient staging; staged values reach the filter only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b0_stage <= '0;
      b1_stage <= '0;
      fir_b0   <= '0;
      fir_b1   <= '0;
      pending  <= 1'b0;
    end else begin
      if ((state == S_IDLE) && pending) begin
        fir_b0  <= b0_stage;
        fir_b1  <= b1_stage;
        pending <= 1'b0;
      end
      // A write landing in an apply cycle re-arms pending for the next idle cycle.
      if (wr_b0) begin
        b0_stage <= cfg_wdata;
        pending  <= 1'b1;
      end
      if (wr_b1) begin
        b1_stage <= cfg_wdata;
        pending  <= 1'b1;
      end
    end
  end

  // Drop status: sticky overrun and saturating counter; a clear beats a drop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_cnt != {CNT_W{1'b1}}) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
